// File: rtl/cross_add_seq_ctrl.sv
// Beat sequencer for one cross-add pass: issues addresses 0..2^n-1 under enable/backpressure,
// waits for the datapath to drain, then pulses done.
module cross_add_seq_ctrl #(
  parameter int ADDR_WIDTH    = 12,
  parameter int LEVEL_WIDTH   = 4,
  parameter int DRAIN_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [LEVEL_WIDTH-1:0] i_n,
  input  logic                   i_s7_mode,
  input  logic                   i_en,
  input  logic                   i_hold,
  input  logic                   i_clear,
  output logic [ADDR_WIDTH-1:0]  o_addr_vpu,
  output logic                   o_we_vpu,
  output logic                   o_done_vpu,
  output logic                   o_s7_mode,
  output logic [LEVEL_WIDTH-1:0] o_n,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int DW = (DRAIN_LATENCY < 2) ? 1 : $clog2(DRAIN_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   done_vpu_q, done_vpu_d;
  logic [LEVEL_WIDTH-1:0] n_q, n_d;
  logic                   s7_q, s7_d;
  logic [ADDR_WIDTH-1:0]  last_addr;

  // Last beat address is 2^n - 1; levels at or above ADDR_WIDTH saturate to all ones.
  always_comb begin
    last_addr = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      last_addr[i] = (i < int'(n_q));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    n_d     = n_q;
    s7_d    = s7_q;
    if (i_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      drain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            n_d     = i_n;
            s7_d    = i_s7_mode;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (i_en && !i_hold) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == last_addr) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(DRAIN_LATENCY - 1)) begin
            state_d = S_FIN;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Status flags are decoded from the next state so they line up with the state register.
    done_d     = (state_d == S_FIN);
    busy_d     = (state_d != S_IDLE);
    done_vpu_d = (state_d == S_IDLE) || (state_d == S_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drain_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_vpu_q <= 1'b1;
      n_q        <= '0;
      s7_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      done_vpu_q <= done_vpu_d;
      n_q        <= n_d;
      s7_q       <= s7_d;
    end
  end

  assign o_addr_vpu = addr_q;
  assign o_we_vpu   = we_q;
  assign o_done_vpu = done_vpu_q;
  assign o_s7_mode  = s7_q;
  assign o_n        = n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_cross_add_seq_ctrl.sv
// Directed bench for cross_add_seq_ctrl: table of passes plus hand sequences for abort,
// collisions, start-during-FIN and reset mid-drain.
module tb_cross_add_seq_ctrl;

  localparam int AW = 12;
  localparam int LW = 4;
  localparam int DL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_s7_mode, i_en, i_hold, i_clear;
  logic [LW-1:0] i_n;
  logic [AW-1:0] o_addr_vpu;
  logic          o_we_vpu, o_done_vpu, o_s7_mode, o_busy, o_done;
  logic [LW-1:0] o_n;

  cross_add_seq_ctrl #(.ADDR_WIDTH(AW), .LEVEL_WIDTH(LW), .DRAIN_LATENCY(DL)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n(i_n), .i_s7_mode(i_s7_mode),
    .i_en(i_en), .i_hold(i_hold), .i_clear(i_clear), .o_addr_vpu(o_addr_vpu),
    .o_we_vpu(o_we_vpu), .o_done_vpu(o_done_vpu), .o_s7_mode(o_s7_mode), .o_n(o_n),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] n;
    logic          s7;
    logic [31:0]   hold_mask;    // bit k: i_hold high in pass cycle k
    logic [31:0]   en_off_mask;  // bit k: i_en low in pass cycle k
    int            restart_k;    // pass cycle with a stray i_start, -1 for none
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] last_exp = '0;
  int cyc = 0, beat_cnt = 0, done_cnt = 0, last_beat_cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the next expected address; idle cycles hold the last one.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_exp = '0;
    end else begin
      if (o_we_vpu) begin
        beat_cnt++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_beat", o_addr_vpu, -1);
        end else begin
          last_exp = exp_q.pop_front();
          chk("beat_addr", o_addr_vpu, last_exp);
        end
      end else begin
        chk("addr_hold", o_addr_vpu, last_exp);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input vec_t v);
    int len, b0, d0;
    bit seen;
    len = (int'(v.n) >= AW) ? (1 << AW) : (1 << v.n);
    for (int i = 0; i < len; i++) exp_q.push_back(AW'(i));
    b0 = beat_cnt;
    d0 = done_cnt;
    i_n = v.n; i_s7_mode = v.s7; i_start = 1'b1; i_en = 1'b1; i_hold = 1'b0;
    tick();
    i_start = 1'b0; i_n = ~v.n; i_s7_mode = ~v.s7;
    chk("busy_after_start", o_busy, 1);
    chk("done_vpu_run", o_done_vpu, 0);
    chk("latched_n", o_n, v.n);
    chk("latched_s7", o_s7_mode, v.s7);
    seen = 1'b0;
    for (int k = 0; k < len + 80 && !seen; k++) begin
      i_hold  = (k < 32) ? v.hold_mask[k] : 1'b0;
      i_en    = (k < 32) ? !v.en_off_mask[k] : 1'b1;
      i_start = (k == v.restart_k);
      tick();
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0; i_hold = 1'b0; i_en = 1'b1;
    chk("done_seen", seen, 1);
    chk("fin_done_vpu", o_done_vpu, 1);
    chk("fin_n", o_n, v.n);
    chk("fin_s7", o_s7_mode, v.s7);
    tick();
    chk("beat_count", beat_cnt - b0, len);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("drain_latency", done_cyc - last_beat_cyc, DL);
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_done_vpu", o_done_vpu, 1);
    chk("last_addr", o_addr_vpu, len - 1);
    exp_q.delete();
  endtask

  initial begin
    int b0, d0;
    bit seen;
    vecs[0] = '{n: 4'd2,  s7: 1'b1, hold_mask: 32'h0,   en_off_mask: 32'h0,     restart_k: -1};
    vecs[1] = '{n: 4'd3,  s7: 1'b0, hold_mask: 32'h18C, en_off_mask: 32'h0,     restart_k: -1};
    vecs[2] = '{n: 4'd0,  s7: 1'b1, hold_mask: 32'h0,   en_off_mask: 32'h0,     restart_k: -1};
    vecs[3] = '{n: 4'd1,  s7: 1'b0, hold_mask: 32'h0,   en_off_mask: 32'hA,     restart_k: 2};
    vecs[4] = '{n: 4'd3,  s7: 1'b1, hold_mask: 32'h0,   en_off_mask: 32'h0,     restart_k: 4};
    vecs[5] = '{n: 4'd5,  s7: 1'b0, hold_mask: 32'h5555, en_off_mask: 32'hF0000, restart_k: 10};
    vecs[6] = '{n: 4'd12, s7: 1'b0, hold_mask: 32'h0,   en_off_mask: 32'h0,     restart_k: -1};
    vecs[7] = '{n: 4'd15, s7: 1'b1, hold_mask: 32'h0,   en_off_mask: 32'h0,     restart_k: -1};

    rst = 1'b1; i_start = 1'b0; i_n = '0; i_s7_mode = 1'b0;
    i_en = 1'b1; i_hold = 1'b0; i_clear = 1'b0;
    #2;
    chk("rst_we", o_we_vpu, 0);
    chk("rst_addr", o_addr_vpu, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_done_vpu", o_done_vpu, 1);
    chk("rst_n", o_n, 0);
    chk("rst_s7", o_s7_mode, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) run_pass(vecs[v]);

    // Abort: clear right after beat 4, so beat 5 never issues.
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
    b0 = beat_cnt; d0 = done_cnt;
    i_n = 4'd4; i_s7_mode = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (o_we_vpu && o_addr_vpu == AW'(4)) seen = 1'b1;
    end
    chk("abort_reached_beat4", seen, 1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("abort_we", o_we_vpu, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done_vpu", o_done_vpu, 1);
    repeat (10) tick();
    chk("abort_beats", beat_cnt - b0, 5);
    chk("abort_no_done", done_cnt - d0, 0);
    exp_q.delete();
    run_pass(vecs[3]);

    // Start together with clear: no pass.
    b0 = beat_cnt;
    i_n = 4'd2; i_start = 1'b1; i_clear = 1'b1;
    tick();
    i_start = 1'b0; i_clear = 1'b0;
    chk("start_clear_busy", o_busy, 0);
    repeat (6) tick();
    chk("start_clear_beats", beat_cnt - b0, 0);
    chk("start_clear_idle", o_busy, 0);

    // Start presented during FIN is dropped.
    exp_q.push_back(AW'(0));
    b0 = beat_cnt; d0 = done_cnt;
    i_n = 4'd0; i_s7_mode = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    chk("fin_start_done_seen", seen, 1);
    i_n = 4'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("fin_start_busy", o_busy, 0);
    repeat (6) tick();
    chk("fin_start_beats", beat_cnt - b0, 1);
    chk("fin_start_done_cnt", done_cnt - d0, 1);
    chk("fin_start_idle", o_busy, 0);
    exp_q.delete();

    // Reset asserted during DRAIN.
    exp_q.push_back(AW'(0));
    d0 = done_cnt;
    i_n = 4'd0; i_s7_mode = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("pre_rst_we", o_we_vpu, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done_vpu", o_done_vpu, 1);
    chk("mid_rst_we", o_we_vpu, 0);
    chk("mid_rst_addr", o_addr_vpu, 0);
    chk("mid_rst_n", o_n, 0);
    chk("mid_rst_s7", o_s7_mode, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_idle", o_busy, 0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
